mul_wb_drain: RTL and testbench
===============================

# mul_wb_drain

- Receiving end of the multiply-pipeline stage-register protocol: accepts valid/rob_id/result beats from the last M stage register and queues them in a DEPTH-entry FIFO.
- Presents queued entries to the ROB write port with a valid/ready handshake.
- Drives the `stall` input of the upstream stage registers. Those registers hold their payload while `stall` is high and their `valid_out` is high.

## Interface
Parameters:
- WORD_SIZE, default `WORD_SIZE (32): result and pc width
- INSTR_TYPE_SZ, default `INSTR_TYPE_SZ: instruction type width
- ROB_ENTRY_WIDTH, default `ROB_ENTRY_WIDTH: ROB tag width
- DEPTH, default 4: queue entries; power of two, at least 2

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; discards all queued entries
- in_valid  in  1  upstream stage register valid_out
- in_instruction_type  in  INSTR_TYPE_SZ  upstream payload
- in_pc  in  WORD_SIZE  upstream payload
- in_result  in  WORD_SIZE  upstream aluResult_out
- in_rob_id  in  ROB_ENTRY_WIDTH  upstream payload
- stall  out  1  to upstream stage registers; high = entry not accepted this edge
- wb_valid  out  1  head entry present
- wb_ready  in  1  ROB accepts the head entry this edge
- wb_instruction_type  out  INSTR_TYPE_SZ  head payload
- wb_pc  out  WORD_SIZE  head payload
- wb_result  out  WORD_SIZE  head payload
- wb_rob_id  out  ROB_ENTRY_WIDTH  head payload
- count  out  $clog2(DEPTH)+1  current occupancy (debug/perf)

## Operation
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
  - Storage array of DEPTH entries {type, pc, result, rob_id}.
- full = (count == DEPTH); empty = (count == 0).
- stall = full. It depends only on registered state and never on wb_ready; there is no combinational path from wb_ready to stall.
- push = in_valid && !full && !flush. Writes the payload at wr_ptr, then increments wr_ptr.
- pop = wb_valid && wb_ready && !flush. Increments rd_ptr.
- Count update:
  - push && pop: count unchanged.
  - push only: count + 1.
  - pop only: count − 1.
- Payload is captured only on push. When full with in_valid high, the beat is not captured; the upstream register holds it, and it is accepted on the first edge with !full.
- wb_valid = !empty. wb_* present storage[rd_ptr] (first-word fall-through). wb_* are stable while wb_valid && !wb_ready.
- flush:
  - Next edge: count = 0, wr_ptr = rd_ptr = 0.
  - Any push or pop in the same cycle is discarded.
  - flush has priority over push and pop.
- reset:
  - Asynchronous and immediate: count = 0, pointers = 0. Hence wb_valid = 0 and stall = 0.
  - Storage contents are don't-care; wb_* payload outputs read storage[0], value unspecified.
  - A reset mid-operation drops all entries, including those with an in-flight handshake.
- When in_valid is low, the payload is ignored. Upstream stage-register payload holds are not checked.

## Timing
- Latency: a beat pushed at edge N gives wb_valid = 1 with that payload after edge N, when the queue was empty.
- Throughput: 1 push and 1 pop per cycle sustained.
- Full with pop at edge N: stall stays high through edge N, so no push occurs at N. stall falls after edge N and a push can occur at N+1. One bubble occurs at the full boundary; this is accepted.
- Ordering: strict FIFO in arrival order.
- Pointer wrap from DEPTH−1 to 0 has no extra cycle.
- Reset values: stall = 0, wb_valid = 0, count = 0.

## Structure
- Shared package `mul_pipe_pkg`:
  - typedef `mul_entry_t` {instruction_type, pc, result, rob_id}, sized from the global defines.
  - DEPTH default constant.
- One sub-module, `entry_fifo`:
  - Generic parameterised storage plus pointers and count.
  - Push/pop/flush inputs; full/empty/count/head outputs.
  - Async reset.
- `mul_wb_drain` wraps `entry_fifo` with the stall and handshake mapping.

## Test plan
- Single beat: after reset, in_valid = 1 for 1 cycle, rob_id = 3, result = 0x0000_00AB, wb_ready = 1 → wb_valid high for exactly 1 cycle with rob_id = 3, result = 0xAB; count returns to 0.
- Fill: wb_ready = 0, 5 beats with rob_id 1..5 (DEPTH = 4) → stall rises after the 4th push, beat 5 is held, count = 4. wb_ready = 1 → rob_ids drain in order 1,2,3,4,5 with one bubble before 5 is accepted.
- Streaming: 20 back-to-back beats with wb_ready = 1 → no stall, outputs in order, count ≤ 1.
- Wrap: 10 push/pop cycles with random wb_ready → data integrity across pointer wrap; scoreboard matches.
- Flush: 3 queued entries, flush = 1 with in_valid = 1 on the same edge → count = 0 and wb_valid = 0 next cycle; the in-flight beat is dropped.
- Async reset: assert reset between edges with count = 2 → wb_valid, stall and count go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mul_pipe_pkg.sv
// mul_pipe_pkg: shared entry type and queue default for the multiply writeback drain.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif
package mul_pipe_pkg;
    localparam int MUL_WB_DEPTH = 4;
    typedef struct packed {
        logic [`INSTR_TYPE_SZ-1:0]   instruction_type;
        logic [`WORD_SIZE-1:0]       pc;
        logic [`WORD_SIZE-1:0]       result;
        logic [`ROB_ENTRY_WIDTH-1:0] rob_id;
    } mul_entry_t;
endpackage

// File: rtl/entry_fifo.sv
// entry_fifo: generic first-word-fall-through queue with flush and async reset.
module entry_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         rdata
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign rdata = mem_q[rd_q];
    // flush wins over any same-cycle push or pop
    assign wr_d  = flush ? '0 : wr_q + AW'(push);
    assign rd_d  = flush ? '0 : rd_q + AW'(pop);
    assign cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/mul_wb_drain.sv
// mul_wb_drain: queues multiply results from the last M stage and drains them to the ROB write port.
module mul_wb_drain
    import mul_pipe_pkg::*;
#(
    parameter int WORD_SIZE       = `WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
    parameter int DEPTH           = MUL_WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
    input  logic [WORD_SIZE-1:0]       in_pc,
    input  logic [WORD_SIZE-1:0]       in_result,
    input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
    output logic                       stall,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [INSTR_TYPE_SZ-1:0]   wb_instruction_type,
    output logic [WORD_SIZE-1:0]       wb_pc,
    output logic [WORD_SIZE-1:0]       wb_result,
    output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int EW = INSTR_TYPE_SZ + 2 * WORD_SIZE + ROB_ENTRY_WIDTH;
    logic full, empty, push, pop;
    logic [EW-1:0] head;
    // stall comes from registered occupancy only, so wb_ready never reaches it
    assign stall    = full;
    assign wb_valid = !empty;
    assign push     = in_valid && !full && !flush;
    assign pop      = wb_valid && wb_ready && !flush;
    entry_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_instruction_type, in_pc, in_result, in_rob_id}),
        .full  (full),
        .empty (empty),
        .count (count),
        .rdata (head)
    );
    assign {wb_instruction_type, wb_pc, wb_result, wb_rob_id} = head;
endmodule

// File: tb/tb_mul_wb_drain.sv
// tb_mul_wb_drain: directed and random stimulus against a queue-based reference model.
module tb_mul_wb_drain;
    import mul_pipe_pkg::*;
    localparam int WS = `WORD_SIZE;
    localparam int TS = `INSTR_TYPE_SZ;
    localparam int RW = `ROB_ENTRY_WIDTH;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 1, flush = 0, in_valid = 0, wb_ready = 0;
    logic [TS-1:0] in_instruction_type = '0;
    logic [WS-1:0] in_pc = '0, in_result = '0;
    logic [RW-1:0] in_rob_id = '0;
    logic stall, wb_valid;
    logic [TS-1:0] wb_instruction_type;
    logic [WS-1:0] wb_pc, wb_result;
    logic [RW-1:0] wb_rob_id;
    logic [$clog2(DEPTH):0] count;
    int n_chk = 0, n_fail = 0;
    mul_entry_t mq[$];
    logic acc;

    mul_wb_drain #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_instruction_type(in_instruction_type), .in_pc(in_pc),
        .in_result(in_result), .in_rob_id(in_rob_id), .stall(stall),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_instruction_type(wb_instruction_type), .wb_pc(wb_pc),
        .wb_result(wb_result), .wb_rob_id(wb_rob_id), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count", 64'(count), 64'(mq.size()));
        chk("stall", 64'(stall), 64'(mq.size() == DEPTH));
        chk("wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("wb_rob_id", 64'(wb_rob_id), 64'(mq[0].rob_id));
            chk("wb_result", 64'(wb_result), 64'(mq[0].result));
            chk("wb_pc", 64'(wb_pc), 64'(mq[0].pc));
            chk("wb_type", 64'(wb_instruction_type), 64'(mq[0].instruction_type));
        end
    endtask

    // One clock: check what the DUT shows now, drive inputs, advance the model past the next edge.
    task automatic cyc(input logic v, input logic rdy, input logic fl,
                       input logic [RW-1:0] id, input logic [WS-1:0] res, output logic accepted);
        mul_entry_t e, tmp;
        int sz;
        @(negedge clk);
        check_outputs();
        e.instruction_type = TS'($urandom);
        e.pc = WS'($urandom);
        e.result = res;
        e.rob_id = id;
        in_valid = v; wb_ready = rdy; flush = fl;
        in_instruction_type = e.instruction_type; in_pc = e.pc;
        in_result = e.result; in_rob_id = e.rob_id;
        sz = mq.size();
        accepted = v && !fl && sz < DEPTH;
        if (fl) mq.delete();
        else begin
            if (rdy && sz > 0) tmp = mq.pop_front();
            if (accepted) mq.push_back(e);
        end
    endtask

    initial begin
        #12;
        chk("reset_stall", 64'(stall), 64'(0));
        chk("reset_valid", 64'(wb_valid), 64'(0));
        chk("reset_count", 64'(count), 64'(0));
        @(negedge clk);
        reset = 0;

        // single beat
        cyc(1, 1, 0, RW'(3), 32'hAB, acc);
        cyc(0, 1, 0, '0, '0, acc);
        chk("single_rob", 64'(wb_rob_id), 64'(3));
        chk("single_res", 64'(wb_result), 64'(32'hAB));
        cyc(0, 1, 0, '0, '0, acc);
        cyc(0, 1, 0, '0, '0, acc);

        // fill with stall, then drain with the held beat accepted after the bubble
        for (int k = 1; k <= 4; k++) cyc(1, 0, 0, RW'(k), WS'($urandom), acc);
        cyc(1, 0, 0, RW'(5), 32'h55, acc);
        chk("fill_held", 64'(acc), 64'(0));
        chk("fill_stall", 64'(stall), 64'(1));
        chk("fill_count", 64'(count), 64'(4));
        acc = 0;
        for (int t = 0; t < 8 && !acc; t++) cyc(1, 1, 0, RW'(5), 32'h55, acc);
        chk("fill_accept5", 64'(acc), 64'(1));
        for (int t = 0; t < 6; t++) cyc(0, 1, 0, '0, '0, acc);

        // streaming
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1, 0, RW'(k), WS'($urandom), acc);
            chk("stream_acc", 64'(acc), 64'(1));
        end
        cyc(0, 1, 0, '0, '0, acc);
        cyc(0, 1, 0, '0, '0, acc);

        // random traffic with pointer wrap
        for (int k = 0; k < 200; k++)
            cyc(1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, RW'($urandom), WS'($urandom), acc);
        for (int t = 0; t < 6; t++) cyc(0, 1, 0, '0, '0, acc);

        // flush with an in-flight beat
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, RW'(k + 7), WS'($urandom), acc);
        cyc(1, 1, 1, RW'(9), 32'h99, acc);
        cyc(0, 0, 0, '0, '0, acc);
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_valid", 64'(wb_valid), 64'(0));

        // async reset between edges with two queued entries
        cyc(1, 0, 0, RW'(1), WS'($urandom), acc);
        cyc(1, 0, 0, RW'(2), WS'($urandom), acc);
        cyc(0, 0, 0, '0, '0, acc);
        #2 reset = 1;
        #1;
        chk("areset_valid", 64'(wb_valid), 64'(0));
        chk("areset_stall", 64'(stall), 64'(0));
        chk("areset_count", 64'(count), 64'(0));
        mq.delete();
        @(negedge clk);
        reset = 0;
        cyc(1, 1, 0, RW'(6), 32'h66, acc);
        cyc(0, 1, 0, '0, '0, acc);
        @(negedge clk);
        check_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
